aes_word_serializer: RTL and testbench

//  Downstream of the 128-bit synchronous FIFO in the data generator.

---
 rtl/aes_word_serializer.sv | 99 +++++++++
 tb/tb_aes_word_serializer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_word_serializer.sv
// Pops 128-bit words from the upstream FIFO and streams each one to the AES core
// as BEATS valid/ready beats, most-significant beat first, counting completed words.
module aes_word_serializer #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned BEAT_W = 32,
    parameter int unsigned BEATS  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_first,
    output logic              out_last,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              busy
);

    localparam int unsigned BCNT_W = $clog2(BEATS);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [BCNT_W-1:0]  bcnt_q,  bcnt_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bcnt_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcnt_q     <= bcnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Next-state logic; the FIFO strobe is gated by rst so every output is 0 during reset
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bcnt_d     = bcnt_q;
        word_cnt_d = word_cnt_q;
        fifo_rd_en = 1'b0;

        case (state_q)
            IDLE: begin
                fifo_rd_en = !fifo_empty && !rst;
                if (!fifo_empty) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                shreg_d = fifo_data;
                bcnt_d  = '0;
                state_d = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (bcnt_q == LAST_BEAT) begin
                        word_cnt_d = CNT_W'(word_cnt_q + 1'b1);
                        state_d    = IDLE;
                    end else begin
                        shreg_d = shreg_q << BEAT_W;
                        bcnt_d  = BCNT_W'(bcnt_q + 1'b1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stream outputs decode directly from registered state, so they hold until transfer
    always_comb begin
        out_valid = (state_q == SEND);
        out_data  = shreg_q[DATA_W-1 -: BEAT_W];
        out_first = (state_q == SEND) && (bcnt_q == '0);
        out_last  = (state_q == SEND) && (bcnt_q == LAST_BEAT);
        word_cnt  = word_cnt_q;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_aes_word_serializer.sv
// Directed bench for aes_word_serializer: behavioural FIFO upstream, hand-computed beats downstream.
module tb_aes_word_serializer;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned BEAT_W = 32;
    localparam int unsigned BEATS  = 4;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [BEAT_W-1:0] out_data;
    logic              out_first;
    logic              out_last;
    logic [CNT_W-1:0]  word_cnt;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    aes_word_serializer #(
        .DATA_W(DATA_W),
        .BEAT_W(BEAT_W),
        .BEATS (BEATS),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_data (fifo_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last),
        .word_cnt  (word_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered read data updates on the strobe edge
    logic [DATA_W-1:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int beat_total = 0;
    always @(posedge clk) begin
        if (out_valid && out_ready) beat_total <= beat_total + 1;
    end

    task automatic push(input logic [DATA_W-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d, input logic f, input logic l);
        chk({tag, "_valid"}, 128'(out_valid), 128'(1));
        chk({tag, "_data"},  128'(out_data),  128'(d));
        chk({tag, "_first"}, 128'(out_first), 128'(f));
        chk({tag, "_last"},  128'(out_last),  128'(l));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, 128'({fifo_rd_en, out_valid, out_data, out_first, out_last, word_cnt, busy}), 128'(0));
    endtask

    logic [31:0] b3 [4];
    logic        pat [8];
    int          k;
    int          beat_snap;

    initial begin
        // Reset state
        #3;
        chk_all_zero("rst_init");
        tick();
        rst = 1'b0;
        tick();
        chk_all_zero("idle_after_rst");

        // Single word, out_ready held high
        out_ready = 1'b1;
        push(128'h00112233_44556677_8899AABB_CCDDEEFF);
        #1;
        chk("t2_rd_en_pulse", 128'(fifo_rd_en), 128'(1));
        chk("t2_valid_idle", 128'(out_valid), 128'(0));
        tick();
        chk("t2_rd_en_wait", 128'(fifo_rd_en), 128'(0));
        chk("t2_busy_wait", 128'(busy), 128'(1));
        chk("t2_valid_wait", 128'(out_valid), 128'(0));
        tick();
        chk_beat("t2_b0", 32'h00112233, 1'b1, 1'b0);
        tick();
        chk_beat("t2_b1", 32'h44556677, 1'b0, 1'b0);
        tick();
        chk_beat("t2_b2", 32'h8899AABB, 1'b0, 1'b0);
        tick();
        chk_beat("t2_b3", 32'hCCDDEEFF, 1'b0, 1'b1);
        chk("t2_cnt_before", 128'(word_cnt), 128'(0));
        tick();
        chk("t2_valid_done", 128'(out_valid), 128'(0));
        chk("t2_busy_done", 128'(busy), 128'(0));
        chk("t2_word_cnt", 128'(word_cnt), 128'(1));

        // Backpressure: each beat must hold until accepted
        out_ready = 1'b0;
        b3[0] = 32'hDEADBEEF; b3[1] = 32'h01234567; b3[2] = 32'h89ABCDEF; b3[3] = 32'hFEDCBA98;
        pat[0] = 0; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 1; pat[5] = 1; pat[6] = 0; pat[7] = 1;
        push({b3[0], b3[1], b3[2], b3[3]});
        tick();
        tick();
        k = 0;
        for (int i = 0; i < 8; i++) begin
            out_ready = pat[i];
            chk_beat($sformatf("t3_c%0d", i), b3[k], (k == 0), (k == 3));
            tick();
            if (pat[i]) k++;
        end
        chk("t3_transfers", 128'(k), 128'(4));
        chk("t3_valid_done", 128'(out_valid), 128'(0));
        chk("t3_word_cnt", 128'(word_cnt), 128'(2));

        // Empty FIFO: nothing moves
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            chk($sformatf("t4_idle_%0d", i), 128'({fifo_rd_en, out_valid, busy}), 128'(0));
            tick();
        end

        // Reset after two beats accepted
        push(128'h11111111_22222222_33333333_44444444);
        tick();
        tick();
        chk_beat("t5_a0", 32'h11111111, 1'b1, 1'b0);
        tick();
        chk_beat("t5_a1", 32'h22222222, 1'b0, 1'b0);
        tick();
        chk_beat("t5_a2", 32'h33333333, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("t5_async_rst");
        tick();
        chk_all_zero("t5_rst_held");
        rst = 1'b0;
        tick();
        chk("t5_no_stale_beat", 128'({out_valid, busy}), 128'(0));
        push(128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333);
        tick();
        tick();
        chk_beat("t5_b0", 32'hAAAA0000, 1'b1, 1'b0);
        chk("t5_cnt_zero", 128'(word_cnt), 128'(0));
        tick();
        chk_beat("t5_b1", 32'hBBBB1111, 1'b0, 1'b0);
        tick();
        chk_beat("t5_b2", 32'hCCCC2222, 1'b0, 1'b0);
        tick();
        chk_beat("t5_b3", 32'hDDDD3333, 1'b0, 1'b1);
        tick();
        chk("t5_word_cnt", 128'(word_cnt), 128'(1));

        // Counter wrap: 17 back-to-back words, 4-bit word_cnt
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        beat_snap = beat_total;
        for (int j = 0; j < 17; j++) push({32'(j), 32'h1, 32'h2, 32'h3});
        #1;
        for (int t = 1; t <= 102; t++) begin
            tick();
            if (t == 6)   chk("t6_cnt_w1",  128'(word_cnt), 128'(1));
            if (t == 90)  chk("t6_cnt_w15", 128'(word_cnt), 128'(15));
            if (t == 90)  chk("t6_rd_en_w16", 128'(fifo_rd_en), 128'(1));
            if (t == 96)  chk("t6_cnt_w16", 128'(word_cnt), 128'(0));
            if (t == 98)  chk_beat("t6_w17_b0", 32'd16, 1'b1, 1'b0);
        end
        chk("t6_cnt_w17", 128'(word_cnt), 128'(1));
        chk("t6_idle_end", 128'({fifo_rd_en, busy}), 128'(0));
        chk("t6_beats", 128'(beat_total - beat_snap), 128'(68));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
